step_dir_decoder: RTL
=====================

STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd1_000_000, cycles without a step before declaring stopped.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-004 SHALL have ports step and dir, inputs, 1 each: step pulse stream; dir (1 = positive) sampled with step.
REQ-005 SHALL have ports load and set_x, inputs, 1 each, plus x_val, input, 64 signed: position preload.
REQ-006 SHALL have port step_bit, input, 6: position weight of one step (increment = 1<<step_bit).
REQ-007 SHALL have outputs x (64 signed) and period (32 unsigned, clocks between the last two accepted steps).
REQ-008 SHALL have outputs period_valid, dir_out, stopped, reversal (1-cycle pulse) and dir_err (sticky), 1 each.

Function
REQ-009 SHALL accept a step on a rising edge of step: sampled high with the previous sample low.
REQ-010 SHALL update x to x + (1<<step_bit) when dir=1, or x - (1<<step_bit) when dir=0, at the clock edge that accepts the step; one-cycle latency from step high to x.
REQ-011 SHALL wrap x modulo 2^64 with no saturation.
REQ-012 SHALL have load&&set_x load x_val, taking priority over a simultaneous step; that step is dropped, but the interval counter still restarts.
REQ-013 SHALL run a 32-bit interval counter that increments every cycle, saturates at 0xFFFFFFFF and clears on each accepted step.
REQ-014 SHALL use three states:
- IDLE: no step since reset or since timeout.
- ARMED: one step seen.
- RUN: period measured.
REQ-015 SHALL make these transitions:
- IDLE: a step moves to ARMED.
- ARMED: a step loads period (counter+1) and moves to RUN.
- RUN: a step reloads period and stays in RUN.
REQ-016 SHALL, in ARMED or RUN, go to IDLE when the counter reaches TIMEOUT: period_valid=0, stopped=1, period holds its last value.
REQ-017 SHALL drive period_valid=1 only in RUN, and stopped=1 only in IDLE.
REQ-018 SHALL register dir_out from dir on each accepted step.
REQ-019 SHALL pulse reversal for one cycle when an accepted step's dir differs from dir_out, in ARMED or RUN only.
REQ-020 SHALL, on a reversal, force state to ARMED (period_valid=0), because an interval across a reversal is not a velocity.
REQ-021 SHALL set dir_err when dir changes while step is held high; cleared only by reset.
REQ-022 SHALL count an accepted step and a timeout on the same cycle as a step (step wins).

Reset
REQ-023 SHALL, while reset=0, hold: x=0, period=0, period_valid=0, dir_out=0, stopped=1, reversal=0, dir_err=0, counter=0, state=IDLE, previous step sample=0.
REQ-024 SHALL, when reset is asserted mid-run, take effect at the next edge; a step high on the first cycle after release is not accepted until step has been seen low.

Configuration
REQ-025 SHALL, when STEP_DIR_DECODER_SYNC_EN is defined, pass step and dir through a 2-flop synchronizer before edge detection; step-to-x latency becomes 3 cycles and the period value is unchanged.
REQ-026 SHALL, without STEP_DIR_DECODER_SYNC_EN, use step and dir directly; they must then be synchronous to clk.

Structure
REQ-027 SHALL place the state enum, the 64-bit position width, the 32-bit interval width and the counter saturation constant in shared package motion_pkg.
REQ-028 SHALL implement synchronizer plus rising-edge detect as sub-module step_edge_detect, outputs step_rise and dir_s.

Verification
REQ-029 SHALL cover: step_bit=16, 5 steps dir=1 at 100-cycle spacing -> x=0x50000, period=100, period_valid=1 after the 2nd step.
REQ-030 SHALL cover: x preloaded to 0, 3 steps dir=0 with step_bit=0 -> x=-3 (0xFFFF...FFFD).
REQ-031 SHALL cover: TIMEOUT=50, one step then idle 50 cycles -> stopped=1, period_valid=0, period unchanged.
REQ-032 SHALL cover: steady 20-cycle steps dir=1, then one step dir=0 -> one-cycle reversal pulse, period_valid=0, x decremented, period_valid=1 again after the next step.
REQ-033 SHALL cover: load&&set_x with x_val=0x1234 on the same cycle as a step edge -> x=0x1234, step dropped.
REQ-034 SHALL cover: x=0x7FFF_FFFF_FFFF_FFFF, step dir=1 with step_bit=0 -> x=0x8000_0000_0000_0000; dir toggled while step high -> dir_err=1.

Source files
------------

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared widths, constants, state encoding and helpers for the step/dir decoder
package motion_pkg;

  localparam int POS_W = 64;
  localparam int INT_W = 32;

  // Interval counter stops here instead of wrapping back to a short, bogus period
  localparam logic [INT_W-1:0] CNT_SAT = {INT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } motion_state_t;

  function automatic logic [INT_W-1:0] sat_inc(input logic [INT_W-1:0] v);
    return (v == CNT_SAT) ? CNT_SAT : v + INT_W'(1);
  endfunction

endpackage

// File: rtl/step_edge_detect.sv
// rtl/step_edge_detect.sv - optional 2-flop input sync (STEP_DIR_DECODER_SYNC_EN) and step rising-edge detect
module step_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic dir,
  output logic step_rise,
  output logic step_s,
  output logic dir_s
);

`ifdef STEP_DIR_DECODER_SYNC_EN
  logic [1:0] step_sync;
  logic [1:0] dir_sync;

  // Two-stage synchronizer for asynchronous step/dir pins
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_sync <= 2'b00;
      dir_sync  <= 2'b00;
    end else begin
      step_sync <= {step_sync[0], step};
      dir_sync  <= {dir_sync[0], dir};
    end
  end

  assign step_s = step_sync[1];
  assign dir_s  = dir_sync[1];
`else
  assign step_s = step;
  assign dir_s  = dir;
`endif

  logic step_prev;
  logic seen_low;

  // Previous step sample plus a guard so a level held high across reset release is not an edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_prev <= 1'b0;
      seen_low  <= 1'b0;
    end else begin
      step_prev <= step_s;
      if (!step_s) begin
        seen_low <= 1'b1;
      end
    end
  end

  assign step_rise = step_s & ~step_prev & seen_low;

endmodule

// File: rtl/step_dir_decoder.sv
// rtl/step_dir_decoder.sv - step/dir decoder: position, step period, stop/reversal/dir-error flags; STEP_DIR_DECODER_SYNC_EN adds input sync
module step_dir_decoder
  import motion_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    load,
  input  logic                    set_x,
  input  logic signed [POS_W-1:0] x_val,
  input  logic [5:0]              step_bit,
  output logic signed [POS_W-1:0] x,
  output logic [INT_W-1:0]        period,
  output logic                    period_valid,
  output logic                    dir_out,
  output logic                    stopped,
  output logic                    reversal,
  output logic                    dir_err
);

  logic                    step_rise;
  logic                    step_s;
  logic                    dir_s;
  logic                    load_x;
  logic                    accept;
  logic                    is_rev;
  logic signed [POS_W-1:0] inc;
  logic [INT_W-1:0]        count;
  logic                    step_q;
  logic                    dir_q;
  motion_state_t           state;

  step_edge_detect u_edge (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .dir       (dir),
    .step_rise (step_rise),
    .step_s    (step_s),
    .dir_s     (dir_s)
  );

  // A preload wins over a coincident step; that step never reaches the FSM
  assign load_x = load & set_x;
  assign accept = step_rise & ~load_x;
  assign is_rev = (dir_s != dir_out);
  assign inc    = $signed(POS_W'(1) << step_bit);

  // Position accumulator, wraps modulo 2^64
  always_ff @(posedge clk) begin
    if (!reset) begin
      x <= '0;
    end else if (load_x) begin
      x <= x_val;
    end else if (step_rise) begin
      x <= dir_s ? (x + inc) : (x - inc);
    end
  end

  // Interval counter restarts on every step edge, even one dropped by a preload
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (step_rise) begin
      count <= '0;
    end else begin
      count <= sat_inc(count);
    end
  end

  // Motion FSM with registered period, direction and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      period       <= '0;
      period_valid <= 1'b0;
      stopped      <= 1'b1;
      dir_out      <= 1'b0;
      reversal     <= 1'b0;
    end else begin
      reversal <= 1'b0;
      if (accept) begin
        dir_out <= dir_s;
        case (state)
          ST_IDLE: begin
            state        <= ST_ARMED;
            period_valid <= 1'b0;
            stopped      <= 1'b0;
          end
          ST_ARMED, ST_RUN: begin
            stopped <= 1'b0;
            if (is_rev) begin
              // An interval spanning a reversal is not a velocity: re-arm
              reversal     <= 1'b1;
              state        <= ST_ARMED;
              period_valid <= 1'b0;
            end else begin
              period       <= sat_inc(count);
              state        <= ST_RUN;
              period_valid <= 1'b1;
            end
          end
          default: begin
            state        <= ST_IDLE;
            period_valid <= 1'b0;
            stopped      <= 1'b1;
          end
        endcase
      end else if ((state != ST_IDLE) && (count >= TIMEOUT)) begin
        state        <= ST_IDLE;
        period_valid <= 1'b0;
        stopped      <= 1'b1;
      end
    end
  end

  // Sticky flag: dir moved while step was held high
  always_ff @(posedge clk) begin
    if (!reset) begin
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      dir_err <= 1'b0;
    end else begin
      step_q <= step_s;
      dir_q  <= dir_s;
      if (step_s && step_q && (dir_s != dir_q)) begin
        dir_err <= 1'b1;
      end
    end
  end

endmodule
